serial_parity_rx: RTL and testbench

Serial-to-parallel receiver with even-parity check. It accepts a framed bit stream of WIDTH data bits (LSB first) followed by one even-parity bit, and presents the recovered word with a parity-error flag. It is the receive end of the team's XOR-based serial parity transmitter. The parity accumulator is a running XOR built on the existing 2-input XOR gate.

---
 rtl/serial_parity_rx.sv | 104 ++++++++++
 tb/tb_serial_parity_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_parity_rx.sv
// Serial-to-parallel receiver: WIDTH data bits LSB first followed by one even-parity bit.
// Presents the recovered word with a parity-error flag and a one-cycle completion pulse.
module serial_parity_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_start,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Single stage of the running-XOR parity chain.
    function automatic logic xor2(input logic a, input logic b);
        return a ^ b;
    endfunction

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic             acc_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_parity_err_q;
    logic             busy_q;

    // Frame FSM: shift register, bit counter, parity accumulator and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            shift_q          <= '0;
            acc_q            <= 1'b0;
            out_valid_q      <= 1'b0;
            out_data_q       <= '0;
            out_parity_err_q <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
                // A start bit restarts the frame from any state; data lands in the MSB
                // and is walked down to bit 0 by the following WIDTH-1 shifts.
                if (in_start) begin
                    state_q <= DATA;
                    cnt_q   <= CNT_W'(1);
                    shift_q <= {in_bit, {(WIDTH-1){1'b0}}};
                    acc_q   <= in_bit;
                    busy_q  <= 1'b1;
                end else begin
                    case (state_q)
                        IDLE: begin
                            state_q <= IDLE;
                        end
                        DATA: begin
                            shift_q <= {in_bit, shift_q[WIDTH-1:1]};
                            acc_q   <= xor2(acc_q, in_bit);
                            cnt_q   <= cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                                state_q <= PARITY;
                            end else begin
                                state_q <= DATA;
                            end
                        end
                        PARITY: begin
                            out_data_q       <= shift_q;
                            out_parity_err_q <= xor2(acc_q, in_bit);
                            out_valid_q      <= 1'b1;
                            state_q          <= IDLE;
                            cnt_q            <= '0;
                            acc_q            <= 1'b0;
                            busy_q           <= 1'b0;
                        end
                        default: begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            acc_q   <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    endcase
                end
            end else begin
                state_q <= state_q;
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_parity_err = out_parity_err_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed self-checking bench for serial_parity_rx with WIDTH=8.
module tb_serial_parity_rx;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_bit;
    logic       in_start;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_parity_err;
    logic       busy;

    int n_checks;
    int n_fail;
    int pulses;
    int busy_low;

    serial_parity_rx #(.WIDTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_bit         (in_bit),
        .in_start       (in_start),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_parity_err (out_parity_err),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One accepted bit; returns 1 time unit after the sampling edge.
    task automatic send_bit(input logic b, input logic s);
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = b;
        in_start = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_start = 1'b0;
        if (out_valid) pulses++;
        if (!busy) busy_low++;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        in_bit   = 1'b1;
        in_start = 1'b1;
        @(posedge clk);
        #1;
        in_start = 1'b0;
        if (out_valid) pulses++;
        if (!busy) busy_low++;
    endtask

    task automatic send_data(input logic [7:0] d, input int gap);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i], (i == 0) ? 1'b1 : 1'b0);
            for (int g = 0; g < gap; g++) idle_cycle();
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_pre_busy got %b want 1", busy); end
        pulse_reset();
        n_checks++;
        if ({out_valid, out_data, out_parity_err, busy} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b d=%h e=%b b=%b want all 0", out_valid, out_data, out_parity_err, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        send_bit(1'b1, 1'b0);
        idle_cycle();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_after got %b want 0", busy); end
    endtask

    task automatic test_good_frame();
        pulses = 0;
        send_data(8'hA5, 0);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL good_before_parity got v=%b b=%b want v=0 b=1", out_valid, busy);
        end
        send_bit(1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL good_valid got %b want 1", out_valid); end
        n_checks++;
        if (out_data !== 8'hA5) begin n_fail++; $display("FAIL good_data got %h want a5", out_data); end
        n_checks++;
        if (out_parity_err !== 1'b0) begin n_fail++; $display("FAIL good_err got %b want 0", out_parity_err); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL good_busy_fall got %b want 0", busy); end
        idle_cycle();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL good_one_cycle got %b want 0", out_valid); end
    endtask

    task automatic test_bad_parity();
        send_data(8'h01, 0);
        send_bit(1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h01 || out_parity_err !== 1'b1) begin
            n_fail++; $display("FAIL bad_result got v=%b d=%h e=%b want v=1 d=01 e=1", out_valid, out_data, out_parity_err);
        end
        idle_cycle();
        idle_cycle();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h01 || out_parity_err !== 1'b1) begin
            n_fail++; $display("FAIL bad_hold got v=%b d=%h e=%b want v=0 d=01 e=1", out_valid, out_data, out_parity_err);
        end
    endtask

    task automatic test_gaps();
        pulses   = 0;
        busy_low = 0;
        send_data(8'h3C, 2);
        n_checks++;
        if (busy_low !== 0 || pulses !== 0) begin
            n_fail++; $display("FAIL gaps_busy got busy_low=%0d pulses=%0d want 0 0", busy_low, pulses);
        end
        send_bit(1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || out_parity_err !== 1'b0) begin
            n_fail++; $display("FAIL gaps_result got v=%b d=%h e=%b want v=1 d=3c e=0", out_valid, out_data, out_parity_err);
        end
    endtask

    task automatic test_resync();
        idle_cycle();
        pulses = 0;
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        send_data(8'h5A, 0);
        send_bit(1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || out_parity_err !== 1'b0) begin
            n_fail++; $display("FAIL resync_result got v=%b d=%h e=%b want v=1 d=5a e=0", out_valid, out_data, out_parity_err);
        end
        idle_cycle();
        n_checks++;
        if (pulses !== 1) begin n_fail++; $display("FAIL resync_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_back_to_back();
        idle_cycle();
        pulses = 0;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        pulse_reset();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_reset got v=%b b=%b want 0 0", out_valid, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        send_data(8'h81, 0);
        send_bit(1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h81 || out_parity_err !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first got v=%b d=%h e=%b want v=1 d=81 e=0", out_valid, out_data, out_parity_err);
        end
        send_data(8'h7F, 0);
        n_checks++;
        if (busy !== 1'b1 || out_data !== 8'h81) begin
            n_fail++; $display("FAIL b2b_second_busy got b=%b d=%h want b=1 d=81", busy, out_data);
        end
        send_bit(1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h7F || out_parity_err !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second got v=%b d=%h e=%b want v=1 d=7f e=0", out_valid, out_data, out_parity_err);
        end
        idle_cycle();
        n_checks++;
        if (pulses !== 2) begin n_fail++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pulses   = 0;
        busy_low = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_start = 1'b0;
        #22;
        rst = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_gaps();
        test_resync();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
